// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: bus widths, aluop encodings,
// divider FSM states and a decode helper for the divide op group.
package ex_stage_pkg;

    localparam int unsigned REG_BUS      = 16;  // operand/result width
    localparam int unsigned REG_ADDR_BUS = 4;   // register-file address width
    localparam int unsigned ALUOP_BUS    = 8;   // aluop encoding width

    localparam logic [7:0] EXE_NOP_OP  = 8'h00;
    localparam logic [7:0] EXE_ADD_OP  = 8'h01;
    localparam logic [7:0] EXE_SUB_OP  = 8'h02;
    localparam logic [7:0] EXE_AND_OP  = 8'h03;
    localparam logic [7:0] EXE_OR_OP   = 8'h04;
    localparam logic [7:0] EXE_XOR_OP  = 8'h05;
    localparam logic [7:0] EXE_SLL_OP  = 8'h06;
    localparam logic [7:0] EXE_SRL_OP  = 8'h07;
    localparam logic [7:0] EXE_SRA_OP  = 8'h08;
    localparam logic [7:0] EXE_SLT_OP  = 8'h09;
    localparam logic [7:0] EXE_MOV_OP  = 8'h0A;
    localparam logic [7:0] EXE_DIVU_OP = 8'h10;
    localparam logic [7:0] EXE_REMU_OP = 8'h11;
    localparam logic [7:0] EXE_DIV_OP  = 8'h12;
    localparam logic [7:0] EXE_REM_OP  = 8'h13;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BUSY,
        DIV_DONE
    } div_state_t;

    function automatic logic is_div_op(input logic [7:0] op);
        return (op == EXE_DIVU_OP) || (op == EXE_REMU_OP) ||
               (op == EXE_DIV_OP)  || (op == EXE_REM_OP);
    endfunction

endpackage

// File: rtl/ex_div.sv
// Iterative restoring divider, one quotient bit per cycle.
// Signed operands are divided as magnitudes and the signs restored on output
// (quotient toward zero, remainder follows the dividend).
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start              begin a division (honoured only in IDLE)
//   signed_op          treat dividend/divisor as two's complement
//   dividend, divisor  operands, sampled on the start edge
//   abort              drop the current division, return to IDLE
//   busy, done         FSM in BUSY / DONE
//   quotient, remainder results, valid while done
module ex_div
    import ex_stage_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         signed_op,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    input  logic         abort,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int unsigned CNT_W = $clog2(W);

    div_state_t       state, state_nxt;
    logic [CNT_W-1:0] count;
    logic [W-1:0]     quo, rem, dvs;
    logic             neg_q, neg_r;
    logic [W-1:0]     abs_a, abs_b;
    logic [W:0]       trial;
    logic             div_zero;

    always_comb begin
        abs_a    = (signed_op && dividend[W-1]) ? -dividend : dividend;
        abs_b    = (signed_op && divisor[W-1])  ? -divisor  : divisor;
        div_zero = (divisor == '0);
        // Shift the next dividend bit into the partial remainder and try the subtract.
        trial    = {rem, quo[W-1]} - {1'b0, dvs};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            DIV_IDLE: if (start) state_nxt = div_zero ? DIV_DONE : DIV_BUSY;
            DIV_BUSY: if (count == CNT_W'(W-1)) state_nxt = DIV_DONE;
            DIV_DONE: state_nxt = DIV_IDLE;
            default:  state_nxt = DIV_IDLE;
        endcase
        if (abort) state_nxt = DIV_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= DIV_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            quo   <= '0;
            rem   <= '0;
            dvs   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (abort) begin
            count <= '0;
        end else begin
            case (state)
                DIV_IDLE: if (start) begin
                    count <= '0;
                    dvs   <= abs_b;
                    if (div_zero) begin
                        // Raw dividend as remainder, all-ones quotient, no sign fixup.
                        quo   <= '1;
                        rem   <= dividend;
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                    end else begin
                        quo   <= abs_a;
                        rem   <= '0;
                        neg_q <= signed_op && (dividend[W-1] ^ divisor[W-1]);
                        neg_r <= signed_op && dividend[W-1];
                    end
                end
                DIV_BUSY: begin
                    count <= count + 1'b1;
                    if (!trial[W]) begin
                        rem <= trial[W-1:0];
                        quo <= {quo[W-2:0], 1'b1};
                    end else begin
                        rem <= {rem[W-2:0], quo[W-1]};
                        quo <= {quo[W-2:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state == DIV_BUSY);
    assign done      = (state == DIV_DONE);
    assign quotient  = neg_q ? -quo : quo;
    assign remainder = neg_r ? -rem : rem;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: combinational ALU plus an iterative divider for DIV/REM.
// Produces the write-back triple (wd/wreg/wdata) for EX/MEM and the ID
// forward path, and requests an upstream stall while a divide is in flight.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   aluop_i       operation code (sole decode source)
//   alusel_i      result class from ID, not used
//   reg1_i/reg2_i operands A/B
//   wd_i/wreg_i   destination register and write enable
//   flush_i       kill current op this cycle
//   wd_o/wreg_o/wdata_o  write-back triple
//   stall_req_o   hold PC, IF/ID, ID/EX
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int unsigned DATA_W     = REG_BUS,
    parameter int unsigned REG_ADDR_W = REG_ADDR_BUS,
    parameter int unsigned ALUOP_W    = ALUOP_BUS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ALUOP_W-1:0]    aluop_i,
    input  logic                  alusel_i,
    input  logic [DATA_W-1:0]     reg1_i,
    input  logic [DATA_W-1:0]     reg2_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic                  flush_i,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [DATA_W-1:0]     wdata_o,
    output logic                  stall_req_o
);

    logic              unused_alusel;
    logic              div_op, div_start, div_busy, div_done, rem_sel;
    logic [DATA_W-1:0] div_quo, div_rem;
    logic [3:0]        shamt;

    assign unused_alusel = alusel_i;
    assign div_op        = is_div_op(8'(aluop_i));
    assign div_start     = div_op && !flush_i;
    assign shamt         = reg2_i[3:0];

    ex_div #(.W(DATA_W)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .signed_op (aluop_i[1]),
        .dividend  (reg1_i),
        .divisor   (reg2_i),
        .abort     (flush_i),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Quotient/remainder choice is captured with the operands when the divider is idle.
    always_ff @(posedge clk) begin
        if (rst)                          rem_sel <= 1'b0;
        else if (!div_busy && !div_done)  rem_sel <= aluop_i[0];
    end

    always_comb begin
        wd_o        = wd_i;
        wreg_o      = 1'b0;
        wdata_o     = '0;
        stall_req_o = 1'b0;
        case (8'(aluop_i))
            EXE_ADD_OP: begin wdata_o = reg1_i + reg2_i;                 wreg_o = wreg_i; end
            EXE_SUB_OP: begin wdata_o = reg1_i - reg2_i;                 wreg_o = wreg_i; end
            EXE_AND_OP: begin wdata_o = reg1_i & reg2_i;                 wreg_o = wreg_i; end
            EXE_OR_OP:  begin wdata_o = reg1_i | reg2_i;                 wreg_o = wreg_i; end
            EXE_XOR_OP: begin wdata_o = reg1_i ^ reg2_i;                 wreg_o = wreg_i; end
            EXE_SLL_OP: begin wdata_o = reg1_i << shamt;                 wreg_o = wreg_i; end
            EXE_SRL_OP: begin wdata_o = reg1_i >> shamt;                 wreg_o = wreg_i; end
            EXE_SRA_OP: begin wdata_o = $signed(reg1_i) >>> shamt;       wreg_o = wreg_i; end
            EXE_SLT_OP: begin
                wdata_o = {{(DATA_W-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
                wreg_o  = wreg_i;
            end
            EXE_MOV_OP: begin wdata_o = reg1_i;                          wreg_o = wreg_i; end
            EXE_DIVU_OP, EXE_REMU_OP, EXE_DIV_OP, EXE_REM_OP: begin
                if (div_done) begin
                    wdata_o = rem_sel ? div_rem : div_quo;
                    wreg_o  = wreg_i;
                end else begin
                    stall_req_o = 1'b1;
                end
            end
            default: ;
        endcase
        if (flush_i) begin
            wreg_o      = 1'b0;
            stall_req_o = 1'b0;
        end
        if (rst) begin
            wd_o        = '0;
            wreg_o      = 1'b0;
            wdata_o     = '0;
            stall_req_o = 1'b0;
        end
    end

endmodule
